// File: rtl/clk_en_gen_pll.sv
// clk_en_gen_pll
//
// Turns the raw PLL lock signal into a qualified lock, then produces NUM_CH
// programmable, phase-aligned clock-enable pulse trains on refclk. Each channel
// also gets its own reset, and these resets are released one after another.
// Everything in this block runs on refclk.
//
// Ports
//   refclk        : sole clock, rising edge
//   rst_n         : asynchronous active-low reset
//   pll_locked    : raw PLL lock, asynchronous to refclk
//   cfg_wr        : one-cycle configuration write strobe
//   cfg_ch        : channel index for the write
//   cfg_div       : new divide value (period = div+1 cycles)
//   cfg_phase     : new phase offset (must not exceed cfg_div)
//   cfg_err       : one-cycle pulse when a write is rejected
//   locked        : qualified lock (FSM in RUN)
//   lock_loss_cnt : saturating count of RUN->IDLE exits
//   ce            : per-channel clock-enable pulses
//   rst_out_n     : per-channel active-low resets, released in sequence
module clk_en_gen_pll #(
   parameter int NUM_CH      = 4,
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 1,
   parameter int LOCK_CYCLES = 16,
   parameter int RST_STAGGER = 4
) (
   input  logic              refclk,
   input  logic              rst_n,
   input  logic              pll_locked,
   input  logic              cfg_wr,
   input  logic [2:0]        cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [DIV_W-1:0]  cfg_phase,
   output logic              cfg_err,
   output logic              locked,
   output logic [7:0]        lock_loss_cnt,
   output logic [NUM_CH-1:0] ce,
   output logic [NUM_CH-1:0] rst_out_n
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] STABLE = 2'd1;
   localparam logic [1:0] RUN    = 2'd2;

   localparam int STAB_W   = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam int STAG_MAX = NUM_CH * RST_STAGGER - 1;
   localparam int RUNC_W   = (STAG_MAX > 0) ? $clog2(STAG_MAX + 1) : 1;

   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_CYCLES - 1);
   localparam logic [RUNC_W-1:0] RUNC_MAX  = RUNC_W'(STAG_MAX);
   localparam logic [3:0]        NUM_CH_L  = 4'(NUM_CH);

   logic              sync_meta;
   logic              sync_lock;
   logic [1:0]        state;
   logic [1:0]        next_state;
   logic [STAB_W-1:0] stab_cnt;
   logic [RUNC_W-1:0] run_cnt;
   logic              cfg_bad;
   logic              cfg_ok;
   logic              direct_upd;

   // Two-flop synchroniser for the asynchronous PLL lock.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta <= 1'b0;
         sync_lock <= 1'b0;
      end else begin
         sync_meta <= pll_locked;
         sync_lock <= sync_meta;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (sync_lock) next_state = STABLE;
         end
         STABLE: begin
            if (!sync_lock)
               next_state = IDLE;
            else if (stab_cnt == STAB_LAST)
               next_state = RUN;
         end
         RUN: begin
            if (!sync_lock) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // locked follows next_state so that it rises on the same edge that enters RUN.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         stab_cnt      <= '0;
         locked        <= 1'b0;
         lock_loss_cnt <= 8'd0;
      end else begin
         state  <= next_state;
         locked <= (next_state == RUN);
         if ((state == STABLE) && (next_state == STABLE))
            stab_cnt <= stab_cnt + STAB_W'(1);
         else
            stab_cnt <= '0;
         if ((state == RUN) && (next_state != RUN) && (lock_loss_cnt != 8'hFF))
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
      end
   end

   // Cycles spent in RUN, saturating once the last channel reset has been released.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n)
         run_cnt <= '0;
      else if (state != RUN)
         run_cnt <= '0;
      else if (run_cnt != RUNC_MAX)
         run_cnt <= run_cnt + RUNC_W'(1);
   end

   assign cfg_bad = ({1'b0, cfg_ch} >= NUM_CH_L) || (cfg_phase > cfg_div);
   assign cfg_ok  = cfg_wr && !cfg_bad;

   // Writes go straight to the active registers unless the channel will keep
   // counting next cycle. When the FSM is about to leave RUN, both a new write
   // and any pending shadow value are applied immediately.
   assign direct_upd = (state != RUN) || (next_state != RUN);

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n)
         cfg_err <= 1'b0;
      else
         cfg_err <= cfg_wr && cfg_bad;
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      localparam logic [2:0]        CH_IDX  = 3'(i);
      localparam logic [RUNC_W-1:0] RST_THR = RUNC_W'((i + 1) * RST_STAGGER - 1);

      logic [DIV_W-1:0] div_q;
      logic [DIV_W-1:0] phase_q;
      logic [DIV_W-1:0] sh_div;
      logic [DIV_W-1:0] sh_phase;
      logic [DIV_W-1:0] cnt;
      logic             pend;
      logic             rst_q;
      logic             sel;
      logic             wrap;

      assign sel  = cfg_ok && (cfg_ch == CH_IDX);
      assign wrap = (state == RUN) && (cnt == div_q);

      // In RUN, a write lands in the shadow and is committed at the next wrap,
      // so a pulse period is never cut short or stretched. A write on the wrap
      // cycle itself is held for the following wrap; the last write wins.
      always_ff @(posedge refclk or negedge rst_n) begin
         if (!rst_n) begin
            div_q    <= DIV_W'(DEFAULT_DIV);
            phase_q  <= '0;
            sh_div   <= '0;
            sh_phase <= '0;
            pend     <= 1'b0;
         end else if (direct_upd) begin
            if (pend) begin
               div_q   <= sh_div;
               phase_q <= sh_phase;
               pend    <= 1'b0;
            end
            if (sel) begin
               div_q   <= cfg_div;
               phase_q <= cfg_phase;
            end
         end else begin
            if (wrap && pend) begin
               div_q   <= sh_div;
               phase_q <= sh_phase;
               pend    <= 1'b0;
            end
            if (sel) begin
               sh_div   <= cfg_div;
               sh_phase <= cfg_phase;
               pend     <= 1'b1;
            end
         end
      end

      // Held at zero outside RUN so every channel starts together on the first RUN cycle.
      always_ff @(posedge refclk or negedge rst_n) begin
         if (!rst_n)
            cnt <= '0;
         else if (state != RUN)
            cnt <= '0;
         else if (wrap)
            cnt <= '0;
         else
            cnt <= cnt + DIV_W'(1);
      end

      always_ff @(posedge refclk or negedge rst_n) begin
         if (!rst_n)
            rst_q <= 1'b0;
         else
            rst_q <= (state == RUN) && (run_cnt >= RST_THR);
      end

      assign ce[i]        = (state == RUN) && (cnt == phase_q);
      assign rst_out_n[i] = rst_q;
   end

endmodule

// File: tb/tb_clk_en_gen_pll.sv
// tb_clk_en_gen_pll
//
// Directed test of clk_en_gen_pll. Stimulus pushes hand-computed expected
// events (cycle number, kind, value) into a scoreboard queue; a monitor on
// the falling edge turns every DUT output event into a lookup in that queue.
// Entries still in the queue at the end are reported as missing events.
module tb_clk_en_gen_pll;

   localparam int NUM_CH = 4;

   localparam int K_LOCKED = 0;
   localparam int K_RST    = 1;
   localparam int K_ERR    = 2;
   localparam int K_CE0    = 3;

   logic              refclk;
   logic              rst_n;
   logic              pll_locked;
   logic              cfg_wr;
   logic [2:0]        cfg_ch;
   logic [7:0]        cfg_div;
   logic [7:0]        cfg_phase;
   logic              cfg_err;
   logic              locked;
   logic [7:0]        lock_loss_cnt;
   logic [NUM_CH-1:0] ce;
   logic [NUM_CH-1:0] rst_out_n;

   typedef struct {
      int         cyc;
      int         kind;
      logic [7:0] val;
   } evt_t;

   evt_t exp_q[$];

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   logic              ce_watch;
   logic              prev_locked = 1'b0;
   logic [NUM_CH-1:0] prev_rst    = '0;

   int ch1_run1[11] = '{30, 34, 38, 42, 46, 52, 57, 61, 65, 69, 73};

   clk_en_gen_pll dut (
      .refclk        (refclk),
      .rst_n         (rst_n),
      .pll_locked    (pll_locked),
      .cfg_wr        (cfg_wr),
      .cfg_ch        (cfg_ch),
      .cfg_div       (cfg_div),
      .cfg_phase     (cfg_phase),
      .cfg_err       (cfg_err),
      .locked        (locked),
      .lock_loss_cnt (lock_loss_cnt),
      .ce            (ce),
      .rst_out_n     (rst_out_n)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   always @(posedge refclk) cyc <= cyc + 1;

   function automatic string kind_name(input int kind);
      case (kind)
         K_LOCKED: return "locked";
         K_RST:    return "rst_out_n";
         K_ERR:    return "cfg_err";
         default:  return $sformatf("ce[%0d]", kind - K_CE0);
      endcase
   endfunction

   task automatic expect_evt(input int c, input int kind, input logic [7:0] val);
      evt_t e;
      e.cyc  = c;
      e.kind = kind;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   task automatic go_to(input int c);
      while (cyc < c) begin
         @(posedge refclk);
         #1;
      end
   endtask

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
      end
   endtask

   // One configuration write lasting one cycle; a rejected write must raise
   // cfg_err on the edge that samples it.
   task automatic applyStimulus(input logic [2:0] ch, input logic [7:0] dv,
                                input logic [7:0] ph, input logic exp_err);
      if (exp_err) expect_evt(cyc + 1, K_ERR, 8'd1);
      cfg_wr    = 1'b1;
      cfg_ch    = ch;
      cfg_div   = dv;
      cfg_phase = ph;
      @(posedge refclk);
      #1;
      cfg_wr = 1'b0;
   endtask

   task automatic score_event(input int kind, input logic [7:0] val);
      int idx = -1;
      for (int i = 0; i < exp_q.size(); i++)
         if (idx < 0 && exp_q[i].cyc == cyc && exp_q[i].kind == kind) idx = i;
      n_vec++;
      if (idx < 0) begin
         n_err++;
         $display("[TB] FAIL %s unexpected event at cycle %0d: got %0h, required no event",
                  kind_name(kind), cyc, val);
      end else begin
         if (exp_q[idx].val !== val) begin
            n_err++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, required %0h",
                     kind_name(kind), cyc, val, exp_q[idx].val);
         end
         exp_q.delete(idx);
      end
   endtask

   always @(negedge refclk) begin
      if (locked !== prev_locked) score_event(K_LOCKED, {7'd0, locked});
      if (rst_out_n !== prev_rst) score_event(K_RST, {4'd0, rst_out_n});
      if (cfg_err === 1'b1) score_event(K_ERR, 8'd1);
      if (ce_watch)
         for (int i = 0; i < NUM_CH; i++)
            if (ce[i] === 1'b1) score_event(K_CE0 + i, 8'd1);
      prev_locked <= locked;
      prev_rst    <= rst_out_n;
   end

   int c0;

   initial begin
      rst_n      = 1'b1;
      pll_locked = 1'b0;
      cfg_wr     = 1'b0;
      cfg_ch     = 3'd0;
      cfg_div    = 8'd0;
      cfg_phase  = 8'd0;
      ce_watch   = 1'b0;
      #1 rst_n   = 1'b0;

      go_to(1);
      checkOutput("reset locked", {7'd0, locked}, 8'd0);
      checkOutput("reset ce", {4'd0, ce}, 8'd0);
      checkOutput("reset rst_out_n", {4'd0, rst_out_n}, 8'd0);
      checkOutput("reset cfg_err", {7'd0, cfg_err}, 8'd0);
      checkOutput("reset lock_loss_cnt", lock_loss_cnt, 8'd0);

      go_to(2);
      rst_n = 1'b1;

      // Pre-lock configuration: ch1 div=3 phase=2, then two rejected writes.
      go_to(4);
      applyStimulus(3'd1, 8'd3, 8'd2, 1'b0);
      go_to(6);
      applyStimulus(3'd5, 8'd3, 8'd0, 1'b1);
      go_to(8);
      applyStimulus(3'd1, 8'd3, 8'd4, 1'b1);

      // First lock: pll_locked sampled at edge 10 -> RUN at edge 28.
      go_to(9);
      expect_evt(28, K_LOCKED, 8'd1);
      expect_evt(75, K_LOCKED, 8'd0);
      expect_evt(32, K_RST, 8'h1);
      expect_evt(36, K_RST, 8'h3);
      expect_evt(40, K_RST, 8'h7);
      expect_evt(44, K_RST, 8'hF);
      expect_evt(76, K_RST, 8'h0);
      for (int c = 28; c <= 74; c += 2) begin
         expect_evt(c, K_CE0 + 0, 8'd1);
         expect_evt(c, K_CE0 + 3, 8'd1);
      end
      for (int j = 0; j < 11; j++) expect_evt(ch1_run1[j], K_CE0 + 1, 8'd1);
      for (int c = 28; c <= 46; c += 2) expect_evt(c, K_CE0 + 2, 8'd1);
      for (int c = 49; c <= 73; c += 3) expect_evt(c, K_CE0 + 2, 8'd1);
      pll_locked = 1'b1;

      go_to(20);
      ce_watch = 1'b1;

      // ch1 div 3->5 written at cnt=1: period 4 completes, then period 6.
      go_to(41);
      applyStimulus(3'd1, 8'd5, 8'd2, 1'b0);
      // ch2 written on its wrap cycle: takes effect one wrap later.
      go_to(45);
      applyStimulus(3'd2, 8'd2, 8'd1, 1'b0);
      // Two writes before ch1's wrap: only the second one is applied.
      go_to(51);
      applyStimulus(3'd1, 8'd7, 8'd0, 1'b0);
      applyStimulus(3'd1, 8'd3, 8'd1, 1'b0);
      // Rejected writes in RUN must leave ch1's schedule untouched.
      go_to(60);
      applyStimulus(3'd1, 8'd3, 8'd4, 1'b1);
      go_to(63);
      applyStimulus(3'd7, 8'd3, 8'd1, 1'b0 | 1'b1);

      // Lock drop with a pending ch1 shadow and a ch0 write on the exit edge.
      go_to(72);
      pll_locked = 1'b0;
      go_to(73);
      applyStimulus(3'd1, 8'd0, 8'd0, 1'b0);
      applyStimulus(3'd0, 8'd2, 8'd2, 1'b0);

      go_to(78);
      checkOutput("lock_loss_cnt after first loss", lock_loss_cnt, 8'd1);
      checkOutput("ce after loss", {4'd0, ce}, 8'd0);

      // Glitch: 8 cycles high, 1 low, then high for good.
      go_to(80);
      pll_locked = 1'b1;
      go_to(81);
      ce_watch = 1'b0;
      go_to(88);
      pll_locked = 1'b0;
      go_to(89);
      expect_evt(108, K_LOCKED, 8'd1);
      expect_evt(133, K_LOCKED, 8'd0);
      expect_evt(112, K_RST, 8'h1);
      expect_evt(116, K_RST, 8'h3);
      expect_evt(120, K_RST, 8'h7);
      expect_evt(124, K_RST, 8'hF);
      expect_evt(134, K_RST, 8'h0);
      for (int c = 110; c <= 127; c += 3) expect_evt(c, K_CE0 + 0, 8'd1);
      for (int c = 108; c <= 127; c += 1) expect_evt(c, K_CE0 + 1, 8'd1);
      for (int c = 109; c <= 127; c += 3) expect_evt(c, K_CE0 + 2, 8'd1);
      for (int c = 108; c <= 127; c += 2) expect_evt(c, K_CE0 + 3, 8'd1);
      pll_locked = 1'b1;

      go_to(100);
      checkOutput("lock_loss_cnt after glitch", lock_loss_cnt, 8'd1);
      ce_watch = 1'b1;
      go_to(128);
      ce_watch = 1'b0;
      go_to(130);
      pll_locked = 1'b0;
      go_to(135);
      checkOutput("lock_loss_cnt after second loss", lock_loss_cnt, 8'd2);

      // Repeated lock/loss cycles to drive the loss counter into saturation.
      go_to(140);
      for (int k = 1; k <= 300; k++) begin
         c0 = cyc;
         expect_evt(c0 + 19, K_LOCKED, 8'd1);
         expect_evt(c0 + 22, K_LOCKED, 8'd0);
         pll_locked = 1'b1;
         go_to(c0 + 19);
         pll_locked = 1'b0;
         go_to(c0 + 22);
         if (k == 252) checkOutput("lock_loss_cnt at 254", lock_loss_cnt, 8'd254);
         if (k == 253) checkOutput("lock_loss_cnt at 255", lock_loss_cnt, 8'd255);
      end
      checkOutput("lock_loss_cnt saturated", lock_loss_cnt, 8'd255);

      // Lock once more, then assert rst_n mid-cycle.
      c0 = cyc;
      expect_evt(c0 + 19, K_LOCKED, 8'd1);
      expect_evt(c0 + 23, K_RST, 8'h1);
      expect_evt(c0 + 27, K_RST, 8'h3);
      expect_evt(c0 + 31, K_RST, 8'h7);
      expect_evt(c0 + 35, K_RST, 8'hF);
      expect_evt(c0 + 40, K_LOCKED, 8'd0);
      expect_evt(c0 + 40, K_RST, 8'h0);
      pll_locked = 1'b1;
      go_to(c0 + 40);
      rst_n = 1'b0;
      #1;
      checkOutput("async reset locked", {7'd0, locked}, 8'd0);
      checkOutput("async reset ce", {4'd0, ce}, 8'd0);
      checkOutput("async reset rst_out_n", {4'd0, rst_out_n}, 8'd0);
      checkOutput("async reset lock_loss_cnt", lock_loss_cnt, 8'd0);
      go_to(c0 + 44);

      foreach (exp_q[i]) begin
         n_vec++;
         n_err++;
         $display("[TB] FAIL %s missing event: got none at cycle %0d, required %0h",
                  kind_name(exp_q[i].kind), exp_q[i].cyc, exp_q[i].val);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/clk_en_gen_pll.md
Name: clk_en_gen_pll

Overview:
- Parametrised, multi-channel successor to the single-PLL clock wrapper, running in one reference clock domain.
- Qualifies a raw PLL lock indication: synchronises it, debounces it with a stabilisation count and tracks lock loss.
- Once lock is qualified, generates NUM_CH programmable, phase-aligned clock-enable pulse trains.
- Each channel has a staggered synchronous reset release.
- Downstream SDRAM/CPU logic runs on refclk gated by these enables instead of extra PLL outputs.

Parameters:
- NUM_CH, 4, number of clock-enable channels (1..8).
- DIV_W, 8, width of the per-channel divide and phase registers.
- DEFAULT_DIV, 1, reset divide value for every channel (period = div+1 cycles).
- LOCK_CYCLES, 16, consecutive synchronised-lock cycles required before RUN (>=1).
- RST_STAGGER, 4, cycles between successive channel reset releases (>=1).

Ports:
- refclk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pll_locked  in  1  raw lock from the PLL, asynchronous to refclk.
- cfg_wr  in  1  config write strobe, one cycle.
- cfg_ch  in  3  target channel index.
- cfg_div  in  DIV_W  new divide value.
- cfg_phase  in  DIV_W  new phase offset.
- cfg_err  out  1  one-cycle pulse: write rejected.
- locked  out  1  qualified lock (FSM in RUN).
- lock_loss_cnt  out  8  saturating count of RUN->IDLE exits.
- ce  out  NUM_CH  per-channel clock-enable pulses.
- rst_out_n  out  NUM_CH  per-channel active-low reset, deasserted in sequence.

Behaviour:
- Reset values: locked=0, ce=0, rst_out_n=0, cfg_err=0, lock_loss_cnt=0; all div=DEFAULT_DIV, phase=0; FSM in IDLE.
- pll_locked passes through a 2-flop synchroniser to give sync_lock.
- FSM:
  - IDLE: stab_cnt=0. Goes to STABLE when sync_lock=1.
  - STABLE: stab_cnt increments each cycle sync_lock=1. If sync_lock=0, return to IDLE. When stab_cnt reaches LOCK_CYCLES-1 with sync_lock=1, go to RUN.
  - RUN: if sync_lock=0, go to IDLE and increment lock_loss_cnt, saturating at 255.
- Latency: locked rises exactly 2+LOCK_CYCLES refclk edges after pll_locked is first sampled high, provided it stays high.
- locked=1 iff state==RUN, registered. It drops the cycle after RUN exits.
- Channel counters:
  - Counters are held at 0 outside RUN, and ce=0 outside RUN.
  - All counters start at 0 together on the first RUN cycle, so channels are phase-aligned.
  - cnt counts 0..div, then wraps to 0.
  - ce[i]=1, combinationally from registered cnt, when in RUN and cnt==phase. Period is div+1 cycles.
  - div=0 gives ce high every RUN cycle.
- Staggered reset release:
  - On RUN entry, rst_out_n[0] rises after RST_STAGGER cycles and rst_out_n[i] rises i*RST_STAGGER cycles after rst_out_n[0].
  - On RUN exit, all rst_out_n go to 0 together on the next cycle.
- Config:
  - A write is rejected, with cfg_err=1 for one cycle and no state change, if cfg_ch>=NUM_CH or cfg_phase>cfg_div.
  - Outside RUN, an accepted write updates div/phase immediately.
  - In RUN, an accepted write goes to a per-channel shadow register and is applied at that channel's next wrap (cycle where cnt==old div). This prevents short or long pulses.
  - A second write before the wrap overwrites the shadow; the last write wins.
  - A write coinciding with the wrap cycle is applied at the following wrap.
- Simultaneous events:
  - A lock drop and a config write in the same cycle: the write is accepted into the active registers because the FSM leaves RUN, and a pending shadow is also committed.
  - rst_n assertion at any point returns all state to reset values asynchronously.

Test Plan:
- Lock qualify: rst_n release, pll_locked=1 at cycle 10 -> locked=1 at edge 28 (2+16); rst_out_n[0..3] rise at edges 32/36/40/44.
- Glitch reject: pll_locked high 8 cycles, low 1, high again -> FSM returns to IDLE, locked rises 18 cycles after the second rise, lock_loss_cnt=0.
- Divide/phase: ch1 div=3 phase=2 written before lock -> in RUN, ce[1] at RUN cycles 2,6,10,…; ch0 DEFAULT_DIV=1 -> ce[0] at cycles 0,2,4,….
- Glitch-free update: in RUN, ch1 div 3->5 written at cnt=1 -> old period completes, then 6-cycle period; no pulse gap outside these.
- Errors: cfg_ch=5 or phase=4/div=3 -> cfg_err one cycle, registers unchanged.
- Lock loss: drop pll_locked in RUN -> locked=0, ce=0, rst_out_n=0 within 3 cycles; lock_loss_cnt=1; 300 losses -> saturates at 255.
